// File: rtl/parking_pkg.sv
// Shared phase encoding, ledger FSM states and fee defaults for the parking ledger.
package parking_pkg;

    localparam logic [2:0] PH_IDLE      = 3'd0;
    localparam logic [2:0] PH_ENTRY     = 3'd1;
    localparam logic [2:0] PH_EXIT_SHOW = 3'd2;
    localparam logic [2:0] PH_EXIT_SAVE = 3'd3;

    localparam int RATE_DEFAULT      = 20;
    localparam int GRACE_MIN_DEFAULT = 15;
    localparam int MIN_PER_HOUR      = 60;

    typedef enum logic [2:0] {
        LS_IDLE,
        LS_CHECK,
        LS_ENTRY_WR,
        LS_EXIT_CALC,
        LS_REJECT
    } ledger_state_e;

    function automatic logic is_commit_phase(input logic [2:0] ph);
        return (ph == PH_ENTRY) || (ph == PH_EXIT_SAVE);
    endfunction

endpackage

// File: rtl/fee_calc.sv
// Iterative ceil(elapsed/60) by repeated subtraction, scaled by RATE and saturated.
// done_o is combinational on the final step so a short stay finishes in the start cycle.
module fee_calc
    import parking_pkg::*;
#(
    parameter int TIME_W    = 16,
    parameter int FEE_W     = 16,
    parameter int RATE      = RATE_DEFAULT,
    parameter int GRACE_MIN = GRACE_MIN_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [TIME_W-1:0] elapsed_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [FEE_W-1:0]  fee_o
);

    localparam int PW = TIME_W + 32;

    logic [TIME_W-1:0] rem_q, rem_d;
    logic [TIME_W-1:0] quo_q, quo_d;
    logic              run_q, run_d;
    logic [TIME_W-1:0] cur_rem, cur_quo, hours;
    logic              active, last;
    logic [PW-1:0]     product;

    always_comb begin
        cur_rem = start_i ? elapsed_i : rem_q;
        cur_quo = start_i ? '0 : quo_q;
        active  = start_i | run_q;
        last    = active && (cur_rem <= TIME_W'(MIN_PER_HOUR));
        // Any leftover minutes start another billable hour.
        hours   = cur_quo + TIME_W'(cur_rem != '0);
        product = PW'(hours) * PW'(RATE);

        rem_d = rem_q;
        quo_d = quo_q;
        run_d = 1'b0;
        if (active && !last) begin
            rem_d = cur_rem - TIME_W'(MIN_PER_HOUR);
            quo_d = cur_quo + TIME_W'(1);
            run_d = 1'b1;
        end

        done_o = last;
        if (start_i && (elapsed_i <= TIME_W'(GRACE_MIN))) begin
            fee_o = '0;
        end else if (|product[PW-1:FEE_W]) begin
            fee_o = '1;
        end else begin
            fee_o = product[FEE_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            run_q <= 1'b0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            run_q <= run_d;
        end
    end

    assign busy_o = run_q;

endmodule

// File: rtl/parking_ledger.sv
// Per-slot occupancy ledger: commits entries/exits from the sequencer and computes
// the exit fee from the stored entry minute.
module parking_ledger
    import parking_pkg::*;
#(
    parameter int SLOTS     = 8,
    parameter int SLOT_W    = 3,
    parameter int TIME_W    = 16,
    parameter int FEE_W     = 16,
    parameter int RATE      = RATE_DEFAULT,
    parameter int GRACE_MIN = GRACE_MIN_DEFAULT
) (
    input  logic              ms,
    input  logic              rst_n,
    input  logic [2:0]        state,
    input  logic              activate_save,
    input  logic [SLOT_W-1:0] slot_id,
    input  logic [TIME_W-1:0] now_min,
    output logic [FEE_W-1:0]  fee,
    output logic              fee_valid,
    output logic [SLOT_W:0]   occupied_cnt,
    output logic              full,
    output logic              err,
    output logic              busy
);

    ledger_state_e     state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [TIME_W-1:0] now_q, now_d;
    logic              is_exit_q, is_exit_d;
    logic [SLOTS-1:0]  occ_q, occ_d;
    logic              occ_rd_q;
    logic [TIME_W-1:0] time_rd_q;
    logic [FEE_W-1:0]  fee_q, fee_d;
    logic              fee_valid_q, fee_valid_d;
    logic [SLOT_W:0]   cnt_q, cnt_d;
    logic              full_q, full_d;
    logic              err_q, err_d;

    logic              occ_set, occ_clr, ram_we;
    logic              calc_start, calc_busy, calc_done;
    logic [FEE_W-1:0]  calc_fee;
    logic [TIME_W-1:0] elapsed;

    logic [TIME_W-1:0] entry_time [SLOTS];

    // Modulo subtraction yields the true stay length across a counter wrap.
    assign elapsed = now_q - time_rd_q;

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        now_d       = now_q;
        is_exit_d   = is_exit_q;
        fee_d       = fee_q;
        fee_valid_d = 1'b0;
        err_d       = 1'b0;
        cnt_d       = cnt_q;
        occ_set     = 1'b0;
        occ_clr     = 1'b0;
        ram_we      = 1'b0;
        calc_start  = 1'b0;

        unique case (state_q)
            LS_IDLE: begin
                if (activate_save && is_commit_phase(state)) begin
                    slot_d    = slot_id;
                    now_d     = now_min;
                    is_exit_d = (state == PH_EXIT_SAVE);
                    state_d   = LS_CHECK;
                end
            end
            LS_CHECK: begin
                state_d = is_exit_q ? LS_EXIT_CALC : LS_ENTRY_WR;
            end
            LS_ENTRY_WR: begin
                if (occ_rd_q) begin
                    err_d   = 1'b1;
                    state_d = LS_REJECT;
                end else begin
                    occ_set = 1'b1;
                    ram_we  = 1'b1;
                    cnt_d   = cnt_q + (SLOT_W+1)'(1);
                    state_d = LS_IDLE;
                end
            end
            LS_EXIT_CALC: begin
                if (!occ_rd_q) begin
                    err_d   = 1'b1;
                    state_d = LS_REJECT;
                end else begin
                    calc_start = !calc_busy;
                    if (calc_done) begin
                        fee_d       = calc_fee;
                        fee_valid_d = 1'b1;
                        occ_clr     = 1'b1;
                        cnt_d       = cnt_q - (SLOT_W+1)'(1);
                        state_d     = LS_IDLE;
                    end
                end
            end
            LS_REJECT: begin
                state_d = LS_IDLE;
            end
            default: begin
                state_d = LS_IDLE;
            end
        endcase

        full_d = (cnt_d == (SLOT_W+1)'(SLOTS));
    end

    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
        logic hit;
        assign hit       = (slot_q == SLOT_W'(gi));
        assign occ_d[gi] = (occ_set && hit) ? 1'b1 :
                           (occ_clr && hit) ? 1'b0 : occ_q[gi];
    end

    always_ff @(posedge ms or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LS_IDLE;
            slot_q      <= '0;
            now_q       <= '0;
            is_exit_q   <= 1'b0;
            occ_q       <= '0;
            occ_rd_q    <= 1'b0;
            fee_q       <= '0;
            fee_valid_q <= 1'b0;
            cnt_q       <= '0;
            full_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            now_q       <= now_d;
            is_exit_q   <= is_exit_d;
            occ_q       <= occ_d;
            occ_rd_q    <= occ_q[slot_q];
            fee_q       <= fee_d;
            fee_valid_q <= fee_valid_d;
            cnt_q       <= cnt_d;
            full_q      <= full_d;
            err_q       <= err_d;
        end
    end

    // Entry-time store: contents need no reset, only occupied slots are ever read back.
    always_ff @(posedge ms) begin
        if (ram_we) begin
            entry_time[slot_q] <= now_q;
        end
        time_rd_q <= entry_time[slot_q];
    end

    fee_calc #(
        .TIME_W    (TIME_W),
        .FEE_W     (FEE_W),
        .RATE      (RATE),
        .GRACE_MIN (GRACE_MIN)
    ) u_fee_calc (
        .clk       (ms),
        .rst_n     (rst_n),
        .start_i   (calc_start),
        .elapsed_i (elapsed),
        .busy_o    (calc_busy),
        .done_o    (calc_done),
        .fee_o     (calc_fee)
    );

    assign fee          = fee_q;
    assign fee_valid    = fee_valid_q;
    assign occupied_cnt = cnt_q;
    assign full         = full_q;
    assign err          = err_q;
    assign busy         = (state_q != LS_IDLE);

endmodule

// File: tb/tb_parking_ledger.sv
// Directed table of commits with hand-computed fees, plus busy-drop and mid-calc reset sequences.
module tb_parking_ledger;
    import parking_pkg::*;

    logic        ms = 1'b0;
    logic        rst_n;
    logic [2:0]  state;
    logic        activate_save;
    logic [2:0]  slot_id;
    logic [15:0] now_min;
    logic [15:0] fee;
    logic        fee_valid;
    logic [3:0]  occupied_cnt;
    logic        full;
    logic        err;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    parking_ledger dut (
        .ms            (ms),
        .rst_n         (rst_n),
        .state         (state),
        .activate_save (activate_save),
        .slot_id       (slot_id),
        .now_min       (now_min),
        .fee           (fee),
        .fee_valid     (fee_valid),
        .occupied_cnt  (occupied_cnt),
        .full          (full),
        .err           (err),
        .busy          (busy)
    );

    always #5 ms = ~ms;

    typedef struct {
        logic [2:0]  ph;
        logic [2:0]  slot;
        logic [15:0] now;
        int          exp_err;
        int          exp_fv;
        int          exp_fee;
        int          exp_cnt;
        int          exp_full;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [2:0] ph, input logic [2:0] slot, input logic [15:0] now,
                                input int e_err, input int e_fv, input int e_fee, input int e_cnt,
                                input int e_full, input int e_lat);
        vec_t v;
        v.ph = ph; v.slot = slot; v.now = now;
        v.exp_err = e_err; v.exp_fv = e_fv; v.exp_fee = e_fee;
        v.exp_cnt = e_cnt; v.exp_full = e_full; v.exp_lat = e_lat;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Strobe during cycle 0, then watch from cycle 1 until the ledger returns to idle.
    task automatic run_op(input logic [2:0] ph, input logic [2:0] slot, input logic [15:0] now,
                          output int err_n, output int fv_n, output int lat, output bit timeout);
        @(negedge ms);
        state = ph; slot_id = slot; now_min = now; activate_save = 1'b1;
        @(negedge ms);
        activate_save = 1'b0; state = PH_IDLE;
        err_n = 0; fv_n = 0; lat = 0; timeout = 1'b1;
        for (int c = 1; c <= 2000; c++) begin
            if (c > 1) @(negedge ms);
            if (err === 1'b1) begin err_n++; if (lat == 0) lat = c; end
            if (fee_valid === 1'b1) begin fv_n++; if (lat == 0) lat = c; end
            if (busy === 1'b0) begin timeout = 1'b0; break; end
        end
    endtask

    initial begin
        int  err_n, fv_n, lat;
        bit  tmo;
        vec_t v;

        // Fee column tracks the held value across entries and rejects.
        add(PH_ENTRY,     3'd2, 16'd100,   0, 0,  0, 1, 0, 0);
        add(PH_EXIT_SAVE, 3'd2, 16'd230,   0, 1, 60, 0, 0, 0);
        add(PH_ENTRY,     3'd5, 16'd0,     0, 0, 60, 1, 0, 0);
        add(PH_EXIT_SAVE, 3'd5, 16'd10,    0, 1,  0, 0, 0, 3);
        add(PH_ENTRY,     3'd1, 16'd65530, 0, 0,  0, 1, 0, 0);
        add(PH_EXIT_SAVE, 3'd1, 16'd70,    0, 1, 40, 0, 0, 0);
        for (int s = 0; s < 8; s++)
            add(PH_ENTRY, 3'(s), 16'd1000, 0, 0, 40, s + 1, (s == 7) ? 1 : 0, 0);
        add(PH_ENTRY,     3'd3, 16'd1000,  1, 0, 40, 8, 1, 3);
        add(PH_EXIT_SAVE, 3'd6, 16'd1200,  0, 1, 80, 7, 0, 0);
        add(PH_EXIT_SAVE, 3'd4, 16'd1061,  0, 1, 40, 6, 0, 0);
        add(PH_EXIT_SAVE, 3'd4, 16'd1100,  1, 0, 40, 6, 0, 3);
        add(PH_EXIT_SAVE, 3'd0, 16'd1016,  0, 1, 20, 5, 0, 3);
        add(PH_EXIT_SAVE, 3'd7, 16'd1015,  0, 1,  0, 4, 0, 3);
        add(PH_EXIT_SHOW, 3'd1, 16'd1300,  0, 0,  0, 4, 0, 0);
        add(PH_IDLE,      3'd2, 16'd1300,  0, 0,  0, 4, 0, 0);

        rst_n = 1'b1; state = PH_IDLE; activate_save = 1'b0; slot_id = '0; now_min = '0;
        #2 rst_n = 1'b0;
        #1;
        check("reset_fee", 32'(fee), 0);
        check("reset_cnt", 32'(occupied_cnt), 0);
        check("reset_flags", {28'd0, fee_valid, full, err, busy}, 0);
        repeat (3) @(negedge ms);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            run_op(v.ph, v.slot, v.now, err_n, fv_n, lat, tmo);
            $display("[TB] vec %0d ph=%0d slot=%0d now=%0d -> err=%0d fv=%0d fee=%0d cnt=%0d full=%0d lat=%0d",
                     i, v.ph, v.slot, v.now, err_n, fv_n, fee, occupied_cnt, full, lat);
            check($sformatf("v%0d_timeout", i), 32'(tmo), 0);
            check($sformatf("v%0d_err", i), 32'(err_n), 32'(v.exp_err));
            check($sformatf("v%0d_fee_valid", i), 32'(fv_n), 32'(v.exp_fv));
            check($sformatf("v%0d_fee", i), 32'(fee), 32'(v.exp_fee));
            if (v.exp_err != 0) @(negedge ms);
            check($sformatf("v%0d_cnt", i), 32'(occupied_cnt), 32'(v.exp_cnt));
            check($sformatf("v%0d_full", i), 32'(full), 32'(v.exp_full));
            if (v.exp_lat != 0) check($sformatf("v%0d_latency", i), 32'(lat), 32'(v.exp_lat));
        end

        // Long exit (4000 min -> 67 h -> 1340); a second strobe while busy must be dropped.
        @(negedge ms);
        state = PH_EXIT_SAVE; slot_id = 3'd3; now_min = 16'd5000; activate_save = 1'b1;
        @(negedge ms);
        activate_save = 1'b0; state = PH_IDLE;
        repeat (4) @(negedge ms);
        state = PH_ENTRY; slot_id = 3'd6; activate_save = 1'b1;
        @(negedge ms);
        activate_save = 1'b0; state = PH_IDLE;
        err_n = 0; fv_n = 0; tmo = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            if (err === 1'b1) err_n++;
            if (fee_valid === 1'b1) fv_n++;
            if (busy === 1'b0) begin tmo = 1'b0; break; end
            @(negedge ms);
        end
        repeat (6) begin
            @(negedge ms);
            if (err === 1'b1) err_n++;
        end
        $display("[TB] busy-drop exit slot 3 -> fee=%0d fv=%0d err=%0d cnt=%0d", fee, fv_n, err_n, occupied_cnt);
        check("busy_drop_timeout", 32'(tmo), 0);
        check("busy_drop_fee", 32'(fee), 1340);
        check("busy_drop_fv", 32'(fv_n), 1);
        check("busy_drop_err", 32'(err_n), 0);
        check("busy_drop_cnt", 32'(occupied_cnt), 3);

        // Reset during the divide: everything clears at once and the lost exit never reports.
        @(negedge ms);
        state = PH_EXIT_SAVE; slot_id = 3'd5; now_min = 16'd9000; activate_save = 1'b1;
        @(negedge ms);
        activate_save = 1'b0; state = PH_IDLE;
        repeat (10) @(negedge ms);
        check("midcalc_busy_before", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        $display("[TB] reset mid-calc -> fee=%0d cnt=%0d busy=%0d", fee, occupied_cnt, busy);
        check("midcalc_fee", 32'(fee), 0);
        check("midcalc_cnt", 32'(occupied_cnt), 0);
        check("midcalc_flags", {28'd0, fee_valid, full, err, busy}, 0);
        repeat (2) @(negedge ms);
        rst_n = 1'b1;
        fv_n = 0; err_n = 0;
        repeat (200) begin
            @(negedge ms);
            if (fee_valid === 1'b1) fv_n++;
            if (err === 1'b1) err_n++;
        end
        check("post_reset_no_fv", 32'(fv_n), 0);
        check("post_reset_no_err", 32'(err_n), 0);

        // Bitmap was cleared, so slot 5 accepts a fresh entry.
        run_op(PH_ENTRY, 3'd5, 16'd50, err_n, fv_n, lat, tmo);
        $display("[TB] post-reset entry slot 5 -> err=%0d cnt=%0d", err_n, occupied_cnt);
        check("post_reset_entry_err", 32'(err_n), 0);
        check("post_reset_entry_cnt", 32'(occupied_cnt), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
